// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared CPU constants, access-size encodings and the M->W register layout
package mem_stage_pkg;
  localparam int DM_WORDS_DEF = 4096;
  localparam logic [1:0] HBW_WORD = 2'b00;
  localparam logic [1:0] HBW_HALF = 2'b01;
  localparam logic [1:0] HBW_BYTE = 2'b10;
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [31:0] ao;
    logic [31:0] dr;
    logic        rw;
    logic [4:0]  wr;
    logic        adel;
    logic        ades;
  } mw_t;
  function automatic logic misaligned(input logic [1:0] hbw, input logic [1:0] ofs);
    return hbw == HBW_BYTE ? 1'b0 : hbw == HBW_HALF ? ofs[0] : |ofs;
  endfunction
endpackage

// File: rtl/mem_stage_load_ext.sv
// load_ext: selects the half/byte lane of a memory word and sign/zero extends it
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  ofs,
  input  logic [1:0]  hbw,
  input  logic        sext,
  output logic [31:0] data
);
  logic [15:0] h;
  logic [7:0]  b;
  always_comb begin
    h = ofs[1] ? word[31:16] : word[15:0];
    b = ofs[0] ? h[15:8] : h[7:0];
    data = hbw == HBW_HALF ? {{16{sext & h[15]}}, h} :
           hbw == HBW_BYTE ? {{24{sext & b[7]}}, b} : word;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: data memory with byte-lane stores, extended loads and the M->W pipeline register
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] IR,
  input  logic [31:0] PC,
  input  logic [31:0] PC8,
  input  logic [31:0] AO,
  input  logic [31:0] rt,
  input  logic        memWrite,
  input  logic        memRead,
  input  logic [1:0]  hbw,
  input  logic        dmExt,
  input  logic        regWrite,
  input  logic [4:0]  writereg,
  output logic [31:0] IRO,
  output logic [31:0] PCO,
  output logic [31:0] PC8O,
  output logic [31:0] AOO,
  output logic [31:0] DRO,
  output logic        regWriteO,
  output logic [4:0]  writeregO,
  output logic        adelO,
  output logic        adesO
);
  localparam int AW = $clog2(DM_WORDS);
  logic [31:0]   mem_q [DM_WORDS];
  mw_t           mw_d, mw_q;
  logic [AW-1:0] addr;
  logic          mis, adel;
  logic [3:0]    be;
  logic [31:0]   wd, rd, ext;
  always_comb begin
    addr = AO[AW+1:2];
    mis = misaligned(hbw, AO[1:0]);
    adel = memRead && mis;
    be = !memWrite || stall || mis ? 4'b0000 :
         hbw == HBW_HALF ? (AO[1] ? 4'b1100 : 4'b0011) :
         hbw == HBW_BYTE ? 4'b0001 << AO[1:0] : 4'b1111;
    wd = hbw == HBW_HALF ? {2{rt[15:0]}} : hbw == HBW_BYTE ? {4{rt[7:0]}} : rt;
    rd = mem_q[addr];
  end
  load_ext u_ext (
    .word(rd),
    .ofs (AO[1:0]),
    .hbw (hbw),
    .sext(dmExt),
    .data(ext)
  );
  always_comb begin
    mw_d = mw_q;
    if (!stall) begin
      mw_d = '{ir: IR, pc: PC, pc8: PC8, ao: AO, dr: adel ? 32'h0 : ext,
               rw: regWrite && !adel, wr: writereg, adel: adel, ades: memWrite && mis};
      if (flush) {mw_d.ir, mw_d.rw, mw_d.wr, mw_d.adel, mw_d.ades} = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mw_q <= '0;
      for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      mw_q <= mw_d;
      for (int b = 0; b < 4; b++) if (be[b]) mem_q[addr][8*b +: 8] <= wd[8*b +: 8];
    end
  end
  assign IRO       = mw_q.ir;
  assign PCO       = mw_q.pc;
  assign PC8O      = mw_q.pc8;
  assign AOO       = mw_q.ao;
  assign DRO       = mw_q.dr;
  assign regWriteO = mw_q.rw;
  assign writeregO = mw_q.wr;
  assign adelO     = mw_q.adel;
  assign adesO     = mw_q.ades;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random checks of mem_stage against a byte-array reference model
module tb_mem_stage;
  import mem_stage_pkg::*;
  localparam int MB = DM_WORDS_DEF * 4;
  logic clk = 0, reset = 0, stall = 0, flush = 0;
  logic memWrite = 0, memRead = 0, dmExt = 0, regWrite = 0;
  logic [1:0] hbw = 0;
  logic [4:0] writereg = 0;
  logic [31:0] IR = 0, PC = 0, PC8 = 0, AO = 0, rt = 0;
  logic [31:0] IRO, PCO, PC8O, AOO, DRO;
  logic regWriteO, adelO, adesO;
  logic [4:0] writeregO;
  logic [7:0] mem [MB];
  logic [31:0] e_ir, e_pc, e_pc8, e_ao, e_dr;
  logic [4:0] e_wr;
  logic e_rw, e_adel, e_ades;
  int tests = 0, fails = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .IR(IR), .PC(PC), .PC8(PC8), .AO(AO), .rt(rt),
    .memWrite(memWrite), .memRead(memRead), .hbw(hbw), .dmExt(dmExt),
    .regWrite(regWrite), .writereg(writereg),
    .IRO(IRO), .PCO(PCO), .PC8O(PC8O), .AOO(AOO), .DRO(DRO),
    .regWriteO(regWriteO), .writeregO(writeregO), .adelO(adelO), .adesO(adesO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", t, got, exp);
    end
  endtask

  task automatic chk_all(input string t);
    chk({t, ".IRO"}, IRO, e_ir);
    chk({t, ".PCO"}, PCO, e_pc);
    chk({t, ".PC8O"}, PC8O, e_pc8);
    chk({t, ".AOO"}, AOO, e_ao);
    chk({t, ".DRO"}, DRO, e_dr);
    chk({t, ".regWriteO"}, 32'(regWriteO), 32'(e_rw));
    chk({t, ".writeregO"}, 32'(writeregO), 32'(e_wr));
    chk({t, ".adelO"}, 32'(adelO), 32'(e_adel));
    chk({t, ".adesO"}, 32'(adesO), 32'(e_ades));
  endtask

  task automatic clear_model();
    foreach (mem[i]) mem[i] = 8'h00;
    {e_ir, e_pc, e_pc8, e_ao, e_dr, e_wr, e_rw, e_adel, e_ades} = '0;
  endtask

  task automatic op(input logic w, input logic r, input logic [1:0] h, input logic x,
                    input logic [31:0] a, input logic [31:0] d);
    memWrite = w; memRead = r; hbw = h; dmExt = x; AO = a; rt = d;
    IR = $urandom; PC = $urandom; PC8 = PC + 8; regWrite = r;
    writereg = 5'($urandom); stall = 0; flush = 0;
  endtask

  task automatic cyc(input string t);
    int unsigned n, a, base;
    logic mis;
    logic [31:0] v;
    n = hbw == 2'b01 ? 2 : hbw == 2'b10 ? 1 : 4;
    a = AO % MB;
    mis = a % n != 0;
    base = a - a % 4 + (a % 4) / n * n;
    v = 0;
    for (int k = 0; k < n; k++) v |= 32'(mem[base + k]) << (8 * k);
    if (dmExt && n < 4 && v[8*n-1]) v |= ~((32'h1 << (8 * n)) - 1);
    if (!stall) begin
      e_pc = PC; e_pc8 = PC8; e_ao = AO;
      e_dr = memRead && mis ? 32'h0 : v;
      if (flush) {e_ir, e_rw, e_wr, e_adel, e_ades} = '0;
      else begin
        e_ir = IR; e_wr = writereg;
        e_adel = memRead && mis; e_ades = memWrite && mis;
        e_rw = regWrite && !(memRead && mis);
      end
    end
    @(posedge clk);
    if (!stall && memWrite && !mis)
      for (int k = 0; k < n; k++) mem[a + k] = 8'(rt >> (8 * k));
    #1 chk_all(t);
  endtask

  initial begin
    clear_model();
    #1 reset = 1;
    #1 chk_all("reset");
    @(posedge clk);
    #1 reset = 0;
    op(1, 0, HBW_WORD, 0, 32'h10, 32'h12345678); cyc("sw10");
    op(0, 1, HBW_WORD, 0, 32'h10, 0); cyc("lw10");
    chk("lw_value", DRO, 32'h12345678);
    op(1, 0, HBW_WORD, 0, 32'h10, 0); cyc("sw10_zero");
    op(1, 0, HBW_BYTE, 0, 32'h11, 32'hAB); cyc("sb11");
    op(0, 1, HBW_BYTE, 1, 32'h11, 0); cyc("lb11");
    chk("lb_value", DRO, 32'hFFFFFFAB);
    op(0, 1, HBW_BYTE, 0, 32'h11, 0); cyc("lbu11");
    chk("lbu_value", DRO, 32'h000000AB);
    op(0, 1, HBW_WORD, 0, 32'h10, 0); cyc("lw_after_sb");
    chk("lw_after_sb_value", DRO, 32'h0000AB00);
    op(1, 0, HBW_HALF, 0, 32'h13, 32'hBEEF); cyc("sh13");
    chk("sh13_ades", 32'(adesO), 1);
    op(0, 1, HBW_WORD, 0, 32'h10, 0); cyc("lw_after_sh");
    chk("sh_suppressed", DRO, 32'h0000AB00);
    op(0, 1, HBW_WORD, 0, 32'h12, 0); cyc("lw12");
    chk("lw12_adel", 32'(adelO), 1);
    chk("lw12_dro", DRO, 0);
    chk("lw12_rw", 32'(regWriteO), 0);
    op(0, 1, HBW_WORD, 0, 32'h10, 0); cyc("pre_stall");
    op(1, 0, HBW_WORD, 0, 32'h20, 32'hCAFEF00D); stall = 1; cyc("sw_stall");
    chk("stall_hold_dro", DRO, 32'h0000AB00);
    op(0, 1, HBW_WORD, 0, 32'h20, 0); cyc("lw_after_stall");
    chk("stall_no_write", DRO, 0);
    op(1, 0, HBW_WORD, 0, 32'h20, 32'hCAFEF00D); cyc("sw_nostall");
    op(0, 1, HBW_WORD, 0, 32'h20, 0); cyc("lw_after_commit");
    chk("commit_value", DRO, 32'hCAFEF00D);
    op(1, 0, HBW_WORD, 0, 32'h30, 32'h55); regWrite = 1; flush = 1; cyc("flush_sw");
    chk("flush_iro", IRO, 0);
    chk("flush_rw", 32'(regWriteO), 0);
    op(0, 1, HBW_WORD, 0, 32'h30, 0); cyc("lw_after_flush");
    chk("flush_store_commit", DRO, 32'h55);
    op(0, 0, HBW_WORD, 0, 32'h40, 0); regWrite = 1; stall = 1; flush = 1; cyc("flush_stall");
    chk("flush_stall_rw", 32'(regWriteO), 1);
    op(1, 0, HBW_WORD, 0, 32'h4040, 32'hA5A5A5A5); cyc("sw_wrap");
    op(0, 1, HBW_WORD, 0, 32'h40, 0); cyc("lw_wrap");
    chk("wrap_value", DRO, 32'hA5A5A5A5);
    op(0, 1, HBW_WORD, 0, 32'h10, 0); cyc("pre_reset");
    op(1, 0, HBW_WORD, 0, 32'h10, 32'hFFFFFFFF);
    reset = 1;
    clear_model();
    #1 chk_all("async_reset");
    @(posedge clk);
    #1 reset = 0;
    chk_all("reset_released");
    op(0, 1, HBW_WORD, 0, 32'h10, 0); cyc("lw_after_reset");
    chk("reset_cleared_mem", DRO, 0);
    for (int i = 0; i < 400; i++) begin
      op(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
         32'($urandom_range(0, 63)) | ($urandom_range(0, 7) == 0 ? ($urandom & 32'hFFFFC000) : 32'h0),
         $urandom);
      regWrite = 1'($urandom);
      stall = $urandom_range(0, 7) == 0;
      flush = $urandom_range(0, 7) == 0;
      cyc("rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL declare parameter DM_WORDS, default 4096, meaning the number of 32-bit data-memory words (word address = AO[13:2]).
REQ-002 SHALL declare port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL declare port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL declare port stall, input, 1, which freezes the M->W register and blocks stores.
REQ-005 SHALL declare port flush, input, 1, which loads a bubble into the M->W register.
REQ-006 SHALL declare ports IR, PC, PC8, AO, rt as inputs, 32 each: instruction, PC, PC+8, ALU result/address, and forwarded store data.
REQ-007 SHALL declare ports memWrite and memRead as inputs, 1 each: store or load present in M.
REQ-008 SHALL declare port hbw, input, 2, access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
REQ-009 SHALL declare port dmExt, input, 1: 1 sign-extends, 0 zero-extends sub-word loads.
REQ-010 SHALL declare ports regWrite (input, 1) and writereg (input, 5): destination-register info from E->M.
REQ-011 SHALL declare ports IRO, PCO, PC8O, AOO, DRO as outputs, 32 each: registered W-stage copies, DRO = extended load data.
REQ-012 SHALL declare ports regWriteO (output, 1) and writeregO (output, 5): registered destination info.
REQ-013 SHALL declare ports adelO and adesO as outputs, 1 each: registered load and store misalignment flags.

Function
REQ-014 SHALL compute misalignment combinationally: half with AO[0]=1, word with AO[1:0]!=0.
REQ-015 SHALL, on a rising edge with memWrite=1, stall=0 and no misalignment, write only the addressed lanes: word all 4 bytes, half bytes {AO[1],0}..+1 from rt[15:0], byte lane AO[1:0] from rt[7:0]; other bytes unchanged.
REQ-016 SHALL suppress the store entirely when misaligned and SHALL register adesO=1 for that instruction.
REQ-017 SHALL read the addressed word combinationally, select the half or byte lane by AO[1:0], and extend it per dmExt to 32 bits.
REQ-018 SHALL set DRO to 0 and adelO=1 for a misaligned load; regWriteO SHALL then be 0.
REQ-019 SHALL forward a store-then-load to the same word in the next cycle with the new data (write-first memory, one-cycle load latency into DRO).
REQ-020 SHALL, with stall=1, hold every M->W output and perform no memory write.
REQ-021 SHALL, with flush=1 and stall=0, load IRO=0, regWriteO=0, writeregO=0, flags=0; a store in the same cycle SHALL still commit.
REQ-022 SHALL give stall priority over flush when both are asserted.
REQ-023 SHALL ignore address bits above the DM_WORDS range (wrap-around modulo DM_WORDS).
REQ-024 SHALL otherwise copy IR, PC, PC8, AO, regWrite, writereg to the registered outputs each cycle.

Reset
REQ-025 SHALL, while reset=1, asynchronously force all registered outputs to 0 and clear every memory word to 0.
REQ-026 SHALL discard any store in the cycle reset is asserted; after deassertion normal operation SHALL resume on the next edge.

Structure
REQ-027 SHALL take hbw encodings (HBW_WORD, HBW_HALF, HBW_BYTE) and DM_WORDS default from the shared CPU constants package.
REQ-028 SHALL isolate lane select plus extension in one combinational sub-module load_ext, reusable by the W stage.
REQ-029 SHALL keep the memory array and the M->W register in mem_stage itself.

Verification
REQ-030 SHALL test: sw rt=0x12345678 @AO=0x10, then lw @0x10 -> DRO=0x12345678 one cycle after the load.
REQ-031 SHALL test: sb rt=0xAB @0x11 over word 0 -> lb dmExt=1 gives 0xFFFFFFAB, lbu gives 0x000000AB, lw gives 0x0000AB00.
REQ-032 SHALL test: sh @0x13 -> adesO=1, word at 0x10 unchanged; lw @0x12 -> adelO=1, DRO=0, regWriteO=0.
REQ-033 SHALL test: sw with stall=1 -> memory unchanged, outputs held; same sw with stall=0 -> committed.
REQ-034 SHALL test: flush=1 with regWrite=1 -> IRO=0, regWriteO=0; flush+stall -> outputs held.
REQ-035 SHALL test: reset pulse mid-stream -> all outputs 0 immediately, lw @0x10 afterwards -> DRO=0.
